// File: rtl/out_display_port.sv
// OUT-port responder: captures OUT events into 8 display slots plus an aux register,
// counts events, and scans a slot pair onto an 8-digit active-low 7-segment display.
// Optional: define OUT_DISPLAY_LZB_EN for leading-zero blanking per 4-digit group.
module out_display_port #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             outdisplay,
  input  logic [2:0]       outsel,
  input  logic [15:0]      outval1,
  input  logic [15:0]      outval2,
  input  logic [1:0]       page,
  output logic [7:0]       seg,
  output logic [7:0]       an,
  output logic [15:0]      aux,
  output logic [CNT_W-1:0] out_count
);

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 16;

  logic [SLOT_W-1:0] r_slot [NUM_SLOTS];
  logic [15:0]       r_aux;
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_presc;
  logic [2:0]        r_digit;
  logic [7:0]        r_seg;
  logic [7:0]        r_an;

  logic [2:0]        w_slot_idx;
  logic [SLOT_W-1:0] w_val;
  logic [SLOT_W-1:0] w_shifted;
  logic [3:0]        w_nib;
  logic              w_blank;
  logic [7:0]        w_seg_next;

  // Active-low {dp,g,f,e,d,c,b,a} pattern for one hex nibble, dp dark.
  function automatic logic [7:0] f_hex(input logic [3:0] i_nib);
    logic [7:0] w_code;
    w_code = 8'hFF;
    case (i_nib)
      4'h0: w_code = 8'hC0;
      4'h1: w_code = 8'hF9;
      4'h2: w_code = 8'hA4;
      4'h3: w_code = 8'hB0;
      4'h4: w_code = 8'h99;
      4'h5: w_code = 8'h92;
      4'h6: w_code = 8'h82;
      4'h7: w_code = 8'hF8;
      4'h8: w_code = 8'h80;
      4'h9: w_code = 8'h90;
      4'hA: w_code = 8'h88;
      4'hB: w_code = 8'h83;
      4'hC: w_code = 8'hC6;
      4'hD: w_code = 8'hA1;
      4'hE: w_code = 8'h86;
      4'hF: w_code = 8'h8E;
      default: w_code = 8'hFF;
    endcase
    return w_code;
  endfunction

  // Digits 0..3 come from the even slot of the page, digits 4..7 from the odd slot.
  always_comb begin
    w_slot_idx = {page, r_digit[2]};
    w_val      = r_slot[w_slot_idx];
    w_shifted  = w_val >> {r_digit[1:0], 2'b00};
    w_nib      = 4'(w_shifted);
`ifdef OUT_DISPLAY_LZB_EN
    w_blank    = (r_digit[1:0] != 2'd0) && (w_shifted == '0);
`else
    w_blank    = 1'b0;
`endif
    w_seg_next = w_blank ? 8'hFF : f_hex(w_nib);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) r_slot[i] <= '0;
      r_aux   <= '0;
      r_count <= '0;
      r_presc <= '0;
      r_digit <= '0;
      r_seg   <= 8'hFF;
      r_an    <= 8'hFF;
    end else begin
      if (outdisplay) begin
        r_slot[outsel] <= outval1;
        r_aux          <= outval2;
        r_count        <= r_count + CNT_W'(1);
      end
      if (r_presc == SCAN_DIV - 16'd1) begin
        r_presc <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
      // seg and an both derive from the pre-edge digit, so they stay aligned.
      r_an  <= ~(8'b1 << r_digit);
      r_seg <= w_seg_next;
    end
  end

  assign seg       = r_seg;
  assign an        = r_an;
  assign aux       = r_aux;
  assign out_count = r_count;

endmodule
